ysyx_23060059_axi_xbar_nslv: RTL

//  Parametrised 1-master -> NSLV-slave AXI4 crossbar. It sits between the core-side arbiter and the memory/peripheral slaves.

---
 rtl/ysyx_23060059_axi_xbar_nslv.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060059_axi_xbar_nslv.sv
// 1-master to NSLV-slave AXI4 crossbar with base/mask decode, one outstanding burst per
// direction, and an internal DECERR responder for unmapped addresses.
module ysyx_23060059_axi_xbar_nslv #(
   parameter int                 NSLV     = 3,
   parameter int                 AW       = 32,
   parameter int                 DW       = 64,
   parameter int                 IDW      = 4,
   parameter logic [NSLV*AW-1:0] SLV_BASE = {32'ha000_0000, 32'h0200_0000, 32'h8000_0000},
   parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hff00_0000, 32'hffff_0000, 32'hf800_0000}
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [AW-1:0]         araddr,
   input  logic                  arvalid,
   input  logic [IDW-1:0]        arid,
   input  logic [7:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   output logic                  arready_o,
   input  logic                  rready,
   output logic [DW-1:0]         rdata_o,
   output logic                  rvalid_o,
   output logic [1:0]            rresp_o,
   output logic [IDW-1:0]        rid_o,
   output logic                  rlast_o,
   input  logic [AW-1:0]         awaddr,
   input  logic                  awvalid,
   input  logic [IDW-1:0]        awid,
   input  logic [7:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   output logic                  awready_o,
   input  logic [DW-1:0]         wdata,
   input  logic [DW/8-1:0]       wstrb,
   input  logic                  wvalid,
   input  logic                  wlast,
   output logic                  wready_o,
   input  logic                  bready,
   output logic                  bvalid_o,
   output logic [1:0]            bresp_o,
   output logic [NSLV*AW-1:0]    s_araddr,
   output logic [NSLV*IDW-1:0]   s_arid,
   output logic [NSLV*8-1:0]     s_arlen,
   output logic [NSLV*3-1:0]     s_arsize,
   output logic [NSLV*2-1:0]     s_arburst,
   output logic [NSLV-1:0]       s_arvalid,
   input  logic [NSLV-1:0]       s_arready,
   input  logic [NSLV*DW-1:0]    s_rdata,
   input  logic [NSLV*2-1:0]     s_rresp,
   input  logic [NSLV*IDW-1:0]   s_rid,
   input  logic [NSLV-1:0]       s_rlast,
   input  logic [NSLV-1:0]       s_rvalid,
   output logic [NSLV-1:0]       s_rready,
   output logic [NSLV*AW-1:0]    s_awaddr,
   output logic [NSLV*IDW-1:0]   s_awid,
   output logic [NSLV*8-1:0]     s_awlen,
   output logic [NSLV*3-1:0]     s_awsize,
   output logic [NSLV*2-1:0]     s_awburst,
   output logic [NSLV*DW-1:0]    s_wdata,
   output logic [NSLV*DW/8-1:0]  s_wstrb,
   output logic [NSLV-1:0]       s_wlast,
   output logic [NSLV-1:0]       s_awvalid,
   output logic [NSLV-1:0]       s_wvalid,
   output logic [NSLV-1:0]       s_bready,
   input  logic [NSLV-1:0]       s_awready,
   input  logic [NSLV-1:0]       s_wready,
   input  logic [NSLV-1:0]       s_bvalid,
   input  logic [NSLV*2-1:0]     s_bresp,
   output logic [1:0]            dbg_r_state_o,
   output logic [2:0]            dbg_w_state_o
);
   localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

   // Every channel uses AXI valid/ready: a beat transfers on a cycle where both are 1;
   // valid never waits for ready, ready may depend combinationally on valid.
   typedef enum logic [1:0] {R_IDLE, R_DATA, R_ERR} r_state_e;
   typedef enum logic [2:0] {W_IDLE, W_DATA, W_RESP, W_EDATA, W_ERESP} w_state_e;

   r_state_e r_state_q, r_state_d;
   w_state_e w_state_q, w_state_d;
   logic [SW-1:0]  r_sel_q, r_sel_d, w_sel_q, w_sel_d;
   logic [IDW-1:0] r_id_q, r_id_d;
   logic [7:0]     r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic           ar_hit, aw_hit;
   logic [SW-1:0]  ar_idx, aw_idx;

   // Lowest matching index wins because the loop walks downward.
   function automatic logic [SW:0] decode(input logic [AW-1:0] addr);
      logic          hit;
      logic [SW-1:0] idx;
      hit = 1'b0;
      idx = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            hit = 1'b1;
            idx = SW'(i);
         end
      end
      return {hit, idx};
   endfunction

   assign {ar_hit, ar_idx} = decode(araddr);
   assign {aw_hit, aw_idx} = decode(awaddr);

   assign s_araddr  = {NSLV{araddr}};
   assign s_arid    = {NSLV{arid}};
   assign s_arlen   = {NSLV{arlen}};
   assign s_arsize  = {NSLV{arsize}};
   assign s_arburst = {NSLV{arburst}};
   assign s_awaddr  = {NSLV{awaddr}};
   assign s_awid    = {NSLV{awid}};
   assign s_awlen   = {NSLV{awlen}};
   assign s_awsize  = {NSLV{awsize}};
   assign s_awburst = {NSLV{awburst}};
   assign s_wdata   = {NSLV{wdata}};
   assign s_wstrb   = {NSLV{wstrb}};
   assign s_wlast   = {NSLV{wlast}};

   assign dbg_r_state_o = r_state_q;
   assign dbg_w_state_o = w_state_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         r_sel_q   <= '0;
         w_sel_q   <= '0;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         r_sel_q   <= r_sel_d;
         w_sel_q   <= w_sel_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      r_sel_d   = r_sel_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      unique case (r_state_q)
         R_IDLE: if (arvalid && arready_o) begin
            if (ar_hit) begin
               r_sel_d   = ar_idx;
               r_state_d = R_DATA;
            end else begin
               r_id_d    = arid;
               r_len_d   = arlen;
               r_cnt_d   = '0;
               r_state_d = R_ERR;
            end
         end
         R_DATA: if (rvalid_o && rready && rlast_o) r_state_d = R_IDLE;
         R_ERR: if (rready) begin
            r_cnt_d = r_cnt_q + 8'd1;
            if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      arready_o = 1'b0;
      s_arvalid = '0;
      s_rready  = '0;
      rvalid_o  = 1'b0;
      rdata_o   = '0;
      rresp_o   = 2'b00;
      rid_o     = '0;
      rlast_o   = 1'b0;
      unique case (r_state_q)
         R_IDLE: if (!reset) begin
            if (ar_hit) begin
               s_arvalid[ar_idx] = arvalid;
               arready_o         = s_arready[ar_idx];
            end else begin
               arready_o = 1'b1;
            end
         end
         R_DATA: begin
            rvalid_o          = s_rvalid[r_sel_q];
            s_rready[r_sel_q] = rready;
            if (rvalid_o) begin
               rdata_o = s_rdata[r_sel_q*DW +: DW];
               rresp_o = s_rresp[r_sel_q*2 +: 2];
               rid_o   = s_rid[r_sel_q*IDW +: IDW];
               rlast_o = s_rlast[r_sel_q];
            end
         end
         R_ERR: begin
            rvalid_o = 1'b1;
            rresp_o  = 2'b11;
            rid_o    = r_id_q;
            rlast_o  = (r_cnt_q == r_len_q);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      w_sel_d   = w_sel_q;
      unique case (w_state_q)
         W_IDLE: if (awvalid && awready_o) begin
            w_sel_d   = aw_idx;
            w_state_d = aw_hit ? W_DATA : W_EDATA;
         end
         W_DATA:  if (wvalid && wready_o && wlast) w_state_d = W_RESP;
         W_RESP:  if (bvalid_o && bready) w_state_d = W_IDLE;
         W_EDATA: if (wvalid && wlast) w_state_d = W_ERESP;
         W_ERESP: if (bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awready_o = 1'b0;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_bready  = '0;
      wready_o  = 1'b0;
      bvalid_o  = 1'b0;
      bresp_o   = 2'b00;
      unique case (w_state_q)
         W_IDLE: if (!reset) begin
            if (aw_hit) begin
               s_awvalid[aw_idx] = awvalid;
               awready_o         = s_awready[aw_idx];
            end else begin
               awready_o = 1'b1;
            end
         end
         W_DATA: begin
            s_wvalid[w_sel_q] = wvalid;
            wready_o          = s_wready[w_sel_q];
         end
         W_RESP: begin
            bvalid_o          = s_bvalid[w_sel_q];
            s_bready[w_sel_q] = bready;
            if (bvalid_o) bresp_o = s_bresp[w_sel_q*2 +: 2];
         end
         W_EDATA: wready_o = 1'b1;
         W_ERESP: begin
            bvalid_o = 1'b1;
            bresp_o  = 2'b11;
         end
         default: ;
      endcase
   end
endmodule
